// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe : ID/EX pipeline register of the five-stage MIPS core.
//
// Latches the decoder control word, operands and register fields into EX.
// It also resolves the EX write-destination register, detects load-use
// hazards against the instruction already in EX, and inserts bubbles on
// stall or flush.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_<ctrl>                decoder control bits / ExtOp / ALUctr
//   id_rs/rt/rd/shamt        instruction fields
//   id_pc4/rs_data/rt_data/imm  PC+4, register-file reads, extended immediate
//   flush_i                  kill the instruction entering EX
//   ex_hold_i                freeze EX (later stage busy)
//   stall_o                  load-use stall request to PC and IF/ID
//   ex_*                     registered EX-stage copy, ex_wreg = resolved dest
//
// Optional feature (macro ID_EX_PERF_EN): adds 32-bit wrapping counters
// perf_bubbles (load-use bubbles actually inserted) and perf_flushes
// (cycles with flush_i asserted). Both clear on rst.
// ---------------------------------------------------------------------------
module id_ex_pipe #(
  parameter int         DW     = 32,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_RegDst,
  input  logic          id_RegWr,
  input  logic          id_ALUSrc,
  input  logic          id_MemWr,
  input  logic          id_MemtoReg,
  input  logic          id_Branch,
  input  logic          id_Jump,
  input  logic [1:0]    id_ExtOp,
  input  logic [4:0]    id_ALUctr,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          flush_i,
  input  logic          ex_hold_i,
  output logic          stall_o,
  output logic          ex_valid,
  output logic          ex_RegWr,
  output logic          ex_ALUSrc,
  output logic          ex_MemWr,
  output logic          ex_MemtoReg,
  output logic          ex_Branch,
  output logic          ex_Jump,
  output logic [1:0]    ex_ExtOp,
  output logic [4:0]    ex_ALUctr,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_shamt,
  output logic [4:0]    ex_wreg,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   perf_bubbles,
  output logic [31:0]   perf_flushes
`endif
);

  typedef struct packed {
    logic          valid;
    logic          regwr;
    logic          alusrc;
    logic          memwr;
    logic          memtoreg;
    logic          branch;
    logic          jump;
    logic [1:0]    extop;
    logic [4:0]    aluctr;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    shamt;
    logic [4:0]    wreg;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
  } ex_t;

  ex_t ex_reg;
  ex_t ex_next;
  ex_t id_load;

  // Write enables coming from the decoder may be x for don't-care opcodes.
  // Only a definite 1 counts; everything else becomes 0 before it reaches EX.
  logic [2:0] wen_raw;
  logic [2:0] wen_clean;
  assign wen_raw = {id_MemtoReg, id_MemWr, id_RegWr};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sanitise
      assign wen_clean[gi] = (wen_raw[gi] === 1'b1);
    end
  endgenerate

  logic regwr_clean;
  logic memwr_clean;
  logic memtoreg_clean;
  assign regwr_clean    = wen_clean[0];
  assign memwr_clean    = wen_clean[1];
  assign memtoreg_clean = wen_clean[2];

  // Destination: jal links into RA_REG, R-type uses rd, I-type uses rt.
  // No write means no destination, so hazard logic never matches it.
  logic [4:0] wreg_id;
  always_comb begin
    wreg_id = 5'd0;
    if (regwr_clean && id_valid) begin
      if (id_Jump === 1'b1)        wreg_id = RA_REG;
      else if (id_RegDst === 1'b1) wreg_id = id_rd;
      else                         wreg_id = id_rt;
    end
  end

  // Load-use: a load in EX whose destination is read by the ID instruction.
  logic dep_hit;
  assign dep_hit = (ex_reg.wreg == id_rs) || (ex_reg.wreg == id_rt);
  assign stall_o = !flush_i && id_valid && ex_reg.valid && ex_reg.memtoreg &&
                   ex_reg.regwr && (ex_reg.wreg != 5'd0) && dep_hit;

  // Fields as loaded from ID. Controls with side effects are gated by
  // id_valid so an empty slot can never write, branch or jump.
  always_comb begin
    id_load          = '0;
    id_load.valid    = id_valid;
    id_load.regwr    = id_valid && regwr_clean;
    id_load.memwr    = id_valid && memwr_clean;
    id_load.memtoreg = id_valid && memtoreg_clean;
    id_load.branch   = id_valid && id_Branch;
    id_load.jump     = id_valid && id_Jump;
    id_load.alusrc   = id_ALUSrc;
    id_load.extop    = id_ExtOp;
    id_load.aluctr   = id_ALUctr;
    id_load.rs       = id_rs;
    id_load.rt       = id_rt;
    id_load.shamt    = id_shamt;
    id_load.wreg     = wreg_id;
    id_load.pc4      = id_pc4;
    id_load.rs_data  = id_rs_data;
    id_load.rt_data  = id_rt_data;
    id_load.imm      = id_imm;
  end

  // Update priority: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    ex_next = ex_reg;
    if (flush_i)        ex_next = '0;
    else if (ex_hold_i) ex_next = ex_reg;
    else if (stall_o)   ex_next = '0;
    else                ex_next = id_load;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_reg <= '0;
    else     ex_reg <= ex_next;
  end

  assign ex_valid    = ex_reg.valid;
  assign ex_RegWr    = ex_reg.regwr;
  assign ex_ALUSrc   = ex_reg.alusrc;
  assign ex_MemWr    = ex_reg.memwr;
  assign ex_MemtoReg = ex_reg.memtoreg;
  assign ex_Branch   = ex_reg.branch;
  assign ex_Jump     = ex_reg.jump;
  assign ex_ExtOp    = ex_reg.extop;
  assign ex_ALUctr   = ex_reg.aluctr;
  assign ex_rs       = ex_reg.rs;
  assign ex_rt       = ex_reg.rt;
  assign ex_shamt    = ex_reg.shamt;
  assign ex_wreg     = ex_reg.wreg;
  assign ex_pc4      = ex_reg.pc4;
  assign ex_rs_data  = ex_reg.rs_data;
  assign ex_rt_data  = ex_reg.rt_data;
  assign ex_imm      = ex_reg.imm;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubbles_reg;
  logic [31:0] flushes_reg;

  // stall_o is already low during flush, so only hold needs excluding.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles_reg <= 32'd0;
      flushes_reg <= 32'd0;
    end else begin
      if (stall_o && !ex_hold_i) bubbles_reg <= bubbles_reg + 32'd1;
      if (flush_i)               flushes_reg <= flushes_reg + 32'd1;
    end
  end

  assign perf_bubbles = bubbles_reg;
  assign perf_flushes = flushes_reg;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe : scoreboard bench for id_ex_pipe. A driver applies directed
// and random ID traffic on the falling edge, predicts stall_o and the next EX
// contents with a behavioural model, and queues them; two monitors pop and
// compare (stall_o before the rising edge, ex_* just after it).
// ---------------------------------------------------------------------------
module tb_id_ex_pipe;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_RegDst, id_RegWr, id_ALUSrc, id_MemWr, id_MemtoReg;
  logic id_Branch, id_Jump;
  logic [1:0]    id_ExtOp;
  logic [4:0]    id_ALUctr, id_rs, id_rt, id_rd, id_shamt;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic flush_i, ex_hold_i;
  logic stall_o, ex_valid, ex_RegWr, ex_ALUSrc, ex_MemWr, ex_MemtoReg;
  logic ex_Branch, ex_Jump;
  logic [1:0]    ex_ExtOp;
  logic [4:0]    ex_ALUctr, ex_rs, ex_rt, ex_shamt, ex_wreg;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles, perf_flushes;
`endif

  id_ex_pipe #(.DW(DW), .RA_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_RegDst(id_RegDst),
    .id_RegWr(id_RegWr), .id_ALUSrc(id_ALUSrc), .id_MemWr(id_MemWr),
    .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_Jump(id_Jump),
    .id_ExtOp(id_ExtOp), .id_ALUctr(id_ALUctr), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .flush_i(flush_i), .ex_hold_i(ex_hold_i), .stall_o(stall_o),
    .ex_valid(ex_valid), .ex_RegWr(ex_RegWr), .ex_ALUSrc(ex_ALUSrc),
    .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_ExtOp(ex_ExtOp), .ex_ALUctr(ex_ALUctr),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt), .ex_wreg(ex_wreg),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm)
`ifdef ID_EX_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  // What EX should hold, as one flat record in output-port order.
  typedef struct packed {
    logic valid, regwr, alusrc, memwr, memtoreg, branch, jump;
    logic [1:0] extop;
    logic [4:0] aluctr, rs, rt, shamt, wreg;
    logic [DW-1:0] pc4, rsd, rtd, imm;
  } ex_t;

  ex_t   model_ex;
  bit    model_known = 0;
  ex_t   exp_q[$];
  bit    stall_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    n_bubbles = 0;
  int    n_flushes = 0;

  // Behavioural model of one clock: returns the expected stall for the
  // current inputs and advances model_ex to what EX holds after the edge.
  task automatic cyc();
    bit   hazard;
    bit   writes;
    ex_t  nxt;
    hazard = !flush_i && id_valid && model_ex.valid && model_ex.memtoreg &&
             model_ex.regwr && model_ex.wreg != 0 &&
             (model_ex.wreg == id_rs || model_ex.wreg == id_rt);
    if (model_known) stall_q.push_back(hazard);
    writes = id_valid && (id_RegWr === 1'b1);
    nxt = '0;
    nxt.valid    = id_valid;
    nxt.regwr    = writes;
    nxt.memwr    = id_valid && (id_MemWr === 1'b1);
    nxt.memtoreg = id_valid && (id_MemtoReg === 1'b1);
    nxt.branch   = id_valid && id_Branch;
    nxt.jump     = id_valid && id_Jump;
    nxt.alusrc = id_ALUSrc; nxt.extop = id_ExtOp; nxt.aluctr = id_ALUctr;
    nxt.rs = id_rs; nxt.rt = id_rt; nxt.shamt = id_shamt;
    nxt.pc4 = id_pc4; nxt.rsd = id_rs_data; nxt.rtd = id_rt_data;
    nxt.imm = id_imm;
    if (!writes)                  nxt.wreg = 0;
    else if (id_Jump === 1'b1)    nxt.wreg = 31;
    else if (id_RegDst === 1'b1)  nxt.wreg = id_rd;
    else                          nxt.wreg = id_rt;
    if (rst)            nxt = '0;
    else if (flush_i)   nxt = '0;
    else if (ex_hold_i) nxt = model_ex;
    else if (hazard)    nxt = '0;
    if (!rst && flush_i) n_flushes++;
    if (!rst && hazard && !ex_hold_i) n_bubbles++;
    if (rst) begin
      n_flushes = 0;
      n_bubbles = 0;
    end
    if (rst) model_known = 1;
    if (model_known) exp_q.push_back(nxt);
    model_ex = nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_RegDst = 0; id_RegWr = 0; id_ALUSrc = 0;
    id_MemWr = 0; id_MemtoReg = 0; id_Branch = 0; id_Jump = 0; id_ExtOp = 0;
    id_ALUctr = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0;
    id_pc4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    flush_i = 0; ex_hold_i = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] tbl [5];
    tbl[0] = 5'd0; tbl[1] = 5'd1; tbl[2] = 5'd2; tbl[3] = 5'd8; tbl[4] = 5'd31;
    return tbl[$urandom_range(0, 4)];
  endfunction

  task automatic rand_inputs();
    rst = ($urandom_range(0, 49) == 0);
    id_valid = ($urandom_range(0, 9) != 0);
    id_RegDst = 1'($urandom); id_RegWr = ($urandom_range(0, 3) != 0);
    id_ALUSrc = 1'($urandom); id_MemWr = ($urandom_range(0, 5) == 0);
    id_MemtoReg = ($urandom_range(0, 2) == 0);
    id_Branch = ($urandom_range(0, 7) == 0);
    id_Jump = ($urandom_range(0, 9) == 0);
    id_ExtOp = 2'($urandom); id_ALUctr = 5'($urandom);
    id_rs = pick_reg(); id_rt = pick_reg(); id_rd = pick_reg();
    id_shamt = 5'($urandom);
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom;
    flush_i = ($urandom_range(0, 9) == 0);
    ex_hold_i = ($urandom_range(0, 6) == 0);
  endtask

  // Monitor: EX contents just after each rising edge.
  initial begin
    ex_t got;
    ex_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = {ex_valid, ex_RegWr, ex_ALUSrc, ex_MemWr, ex_MemtoReg, ex_Branch,
               ex_Jump, ex_ExtOp, ex_ALUctr, ex_rs, ex_rt, ex_shamt, ex_wreg,
               ex_pc4, ex_rs_data, ex_rt_data, ex_imm};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL ex_state t=%0t got=%h exp=%h", $time, got, exp);
        end else
          $display("ex  t=%0t ok valid=%0b wreg=%0d regwr=%0b", $time,
                   got.valid, got.wreg, got.regwr);
      end
    end
  end

  // Monitor: stall request, sampled mid-cycle with inputs settled.
  initial begin
    bit exp;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() != 0) begin
        exp = stall_q.pop_front();
        vectors++;
        if (stall_o !== exp) begin
          miscompares++;
          $display("FAIL stall_o t=%0t got=%b exp=%b", $time, stall_o, exp);
        end else
          $display("stl t=%0t ok stall_o=%b", $time, stall_o);
      end
    end
  end

  initial begin
    idle();
    model_ex = '0;
    @(negedge clk);
    // Reset.
    rst = 1; cyc(); cyc();
    // addu $5 pass-through.
    idle(); id_valid = 1; id_RegDst = 1; id_RegWr = 1; id_rd = 5;
    id_rs = 1; id_rt = 2; id_rs_data = 32'h11; id_rt_data = 32'h22; cyc();
    // lw $8 then addu using $8: one bubble, then the addu enters.
    idle(); id_valid = 1; id_RegWr = 1; id_MemtoReg = 1; id_ALUSrc = 1;
    id_rt = 8; id_rs = 3; cyc();
    idle(); id_valid = 1; id_RegDst = 1; id_RegWr = 1; id_rs = 8; id_rt = 4;
    id_rd = 9; cyc(); cyc();
    // Back-to-back dependent loads.
    idle(); id_valid = 1; id_RegWr = 1; id_MemtoReg = 1; id_rt = 8; cyc();
    id_rs = 8; id_rt = 10; cyc(); cyc();
    idle(); id_valid = 1; id_RegDst = 1; id_RegWr = 1; id_rs = 10; id_rd = 6;
    cyc(); cyc();
    // lw into $0 then a use of $0: no stall.
    idle(); id_valid = 1; id_RegWr = 1; id_MemtoReg = 1; id_rt = 0; cyc();
    idle(); id_valid = 1; id_RegDst = 1; id_RegWr = 1; id_rs = 0; id_rd = 7;
    cyc();
    // jal with rd undefined links into $31.
    idle(); id_valid = 1; id_Jump = 1; id_RegWr = 1; id_rd = 5'bx;
    id_pc4 = 32'h400; cyc();
    // Flush and hold together: bubble.
    idle(); id_valid = 1; id_RegWr = 1; id_rt = 3; flush_i = 1; ex_hold_i = 1;
    cyc();
    // Load something, then hold it for 3 cycles with changing ID inputs.
    idle(); id_valid = 1; id_RegDst = 1; id_RegWr = 1; id_rd = 12;
    id_imm = 32'hcafe; cyc();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); rst = 0; flush_i = 0; ex_hold_i = 1; cyc();
    end
    // jr-style decode with MemWr undefined.
    idle(); id_valid = 1; id_RegWr = 0; id_MemWr = 1'bx; id_Jump = 1;
    id_rs = 31; cyc();
    // Reset in the middle of a load-use stall.
    idle(); id_valid = 1; id_RegWr = 1; id_MemtoReg = 1; id_rt = 8; cyc();
    idle(); id_valid = 1; id_RegDst = 1; id_RegWr = 1; id_rs = 8; rst = 1;
    cyc();
    rst = 0; cyc();
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rand_inputs(); cyc();
    end
    idle(); cyc(); cyc();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d pending exp=0", exp_q.size(),
               stall_q.size());
    end
`ifdef ID_EX_PERF_EN
    vectors++;
    if (perf_bubbles !== 32'(n_bubbles)) begin
      miscompares++;
      $display("FAIL perf_bubbles got=%0d exp=%0d", perf_bubbles, n_bubbles);
    end
    vectors++;
    if (perf_flushes !== 32'(n_flushes)) begin
      miscompares++;
      $display("FAIL perf_flushes got=%0d exp=%0d", perf_flushes, n_flushes);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the clocked flow above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
